switch_mode_debouncer: RTL and testbench

SWITCH_MODE_DEBOUNCER -- requirements
Module: switch_mode_debouncer

---
 rtl/switch_mode_debouncer.sv | 88 ++++++++
 tb/tb_switch_mode_debouncer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/switch_mode_debouncer.sv
// rtl/switch_mode_debouncer.sv - two-button debouncer driving a 2-bit mode counter and an enable toggle; optional input synchronizer under BTN_SYNC_EN
module switch_mode_debouncer #(
   parameter int unsigned c_DEBOUNCE_CNT = 250
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_btn_mode,
   input  logic i_btn_enable,
   output logic o_switch_1,
   output logic o_switch_2,
   output logic o_enable,
   output logic o_mode_change
);

   // Counter value on which a differing level becomes the new stable level
   localparam logic [15:0] c_LAST = 16'(c_DEBOUNCE_CNT - 1);

   // Bit 0 is the mode button, bit 1 is the enable button
   logic [1:0] btn_raw;
   logic [1:0] btn_lvl;
   logic [1:0] press;
   logic [1:0] mode_q;
   logic       mode_upd_q;

   assign btn_raw = {i_btn_enable, i_btn_mode};

`ifdef BTN_SYNC_EN
   logic [1:0] sync_a_q;
   logic [1:0] sync_b_q;

   // Two-flop synchronizer on both raw buttons
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync_a_q <= 2'b00;
         sync_b_q <= 2'b00;
      end else begin
         sync_a_q <= btn_raw;
         sync_b_q <= sync_a_q;
      end
   end

   assign btn_lvl = sync_b_q;
`else
   assign btn_lvl = btn_raw;
`endif

   for (genvar g = 0; g < 2; g++) begin : g_btn
      logic [15:0] cnt_q;
      logic        stable_q;

      // Count consecutive samples that differ from the stable level; any agreeing sample restarts the count
      always_ff @(posedge i_clock or negedge i_reset_n) begin
         if (!i_reset_n) begin
            cnt_q    <= 16'd0;
            stable_q <= 1'b0;
         end else if (btn_lvl[g] == stable_q) begin
            cnt_q <= 16'd0;
         end else if (cnt_q == c_LAST) begin
            stable_q <= btn_lvl[g];
            cnt_q    <= 16'd0;
         end else begin
            cnt_q <= cnt_q + 16'd1;
         end
      end

      // A press is the edge on which the stable level is about to go 0->1
      assign press[g] = (btn_lvl[g] != stable_q) && (cnt_q == c_LAST) && btn_lvl[g];
   end

   // Mode advance, enable toggle and the delayed mode-change strobe
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         mode_q        <= 2'b00;
         o_enable      <= 1'b0;
         mode_upd_q    <= 1'b0;
         o_mode_change <= 1'b0;
      end else begin
         mode_q        <= mode_q + {1'b0, press[0]};
         o_enable      <= o_enable ^ press[1];
         mode_upd_q    <= press[0];
         o_mode_change <= mode_upd_q;
      end
   end

   assign o_switch_1 = mode_q[1];
   assign o_switch_2 = mode_q[0];

endmodule

// File: tb/tb_switch_mode_debouncer.sv
// tb/tb_switch_mode_debouncer.sv - randomized and directed bench with a sample-window reference model
module tb_switch_mode_debouncer;

   localparam int CNT = 4;
`ifdef BTN_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif
   localparam int LAT = CNT + SYNC;

   logic i_clock = 1'b0;
   logic i_reset_n = 1'b1;
   logic i_btn_mode = 1'b0;
   logic i_btn_enable = 1'b0;
   logic o_switch_1, o_switch_2, o_enable, o_mode_change;

   int checks = 0;
   int errors = 0;

   // Reference state: raw samples per edge, stable levels, outputs
   logic [1:0] hist[$];
   bit         st_m, st_e;
   logic [1:0] m_mode;
   logic       m_en, m_pend, m_chg;

   switch_mode_debouncer #(.c_DEBOUNCE_CNT(CNT)) dut (
      .i_clock      (i_clock),
      .i_reset_n    (i_reset_n),
      .i_btn_mode   (i_btn_mode),
      .i_btn_enable (i_btn_enable),
      .o_switch_1   (o_switch_1),
      .o_switch_2   (o_switch_2),
      .o_enable     (o_enable),
      .o_mode_change(o_mode_change)
   );

   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // The stable level flips once the last CNT effective samples all disagree with it
   function automatic bit flips(input int b, input bit st);
      for (int j = 0; j < CNT; j++) begin
         int  idx;
         bit  lvl;
         idx = hist.size() - 1 - SYNC - j;
         lvl = (idx >= 0) ? hist[idx][b] : 1'b0;
         if (lvl == st) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_clear();
      hist.delete();
      st_m = 0; st_e = 0;
      m_mode = 2'b00; m_en = 0; m_pend = 0; m_chg = 0;
   endtask

   task automatic model_edge(input bit m, input bit e);
      bit fm, fe;
      hist.push_back({e, m});
      if (hist.size() > 64) void'(hist.pop_front());
      fm = flips(0, st_m);
      fe = flips(1, st_e);
      m_chg = m_pend;
      m_pend = 0;
      if (fm) begin
         st_m = !st_m;
         if (st_m) begin
            m_mode = m_mode + 2'd1;
            m_pend = 1;
         end
      end
      if (fe) begin
         st_e = !st_e;
         if (st_e) m_en = !m_en;
      end
   endtask

   task automatic check_all();
      check("mode", {o_switch_1, o_switch_2}, m_mode);
      check("enable", {1'b0, o_enable}, {1'b0, m_en});
      check("mode_change", {1'b0, o_mode_change}, {1'b0, m_chg});
   endtask

   // Called at a falling edge: drive inputs, take one rising edge, compare at the next falling edge
   task automatic step(input bit m, input bit e);
      i_btn_mode = m;
      i_btn_enable = e;
      @(posedge i_clock);
      if (i_reset_n) model_edge(m, e);
      @(negedge i_clock);
      check_all();
   endtask

   task automatic reset_pulse();
      i_reset_n = 1'b0;
      #1;
      model_clear();
      check_all();
      @(posedge i_clock);
      @(negedge i_clock);
      check_all();
      i_reset_n = 1'b1;
   endtask

   initial begin
      logic [1:0] mode_before;
      logic       en_before;
      bit         rm, re;

      model_clear();
      @(negedge i_clock);
      reset_pulse();

      // Idle after reset
      repeat (10) step(0, 0);

      // Single held mode press: latency, one strobe, no action on release
      for (int k = 1; k <= 20; k++) begin
         step(1, 0);
         if (k == LAT - 1) check("pre_press_mode", {o_switch_1, o_switch_2}, 2'b00);
         if (k == LAT) check("press_mode", {o_switch_1, o_switch_2}, 2'b01);
         if (k == LAT) check("strobe_early", {1'b0, o_mode_change}, 2'b00);
         if (k == LAT + 1) check("strobe", {1'b0, o_mode_change}, 2'b01);
         if (k == LAT + 2) check("strobe_end", {1'b0, o_mode_change}, 2'b00);
      end
      repeat (10) step(0, 0);
      check("release_mode", {o_switch_1, o_switch_2}, 2'b01);

      // Four clean presses walk through the wrap
      for (int p = 0; p < 4; p++) begin
         repeat (8) step(1, 0);
         repeat (8) step(0, 0);
      end
      check("four_presses", {o_switch_1, o_switch_2}, 2'b01);

      // Short enable pulses are rejected; only the held phase toggles
      en_before = o_enable;
      for (int p = 0; p < 5; p++) begin
         repeat (3) step(0, 1);
         step(0, 0);
      end
      check("glitch_enable", {1'b0, o_enable}, {1'b0, en_before});
      repeat (10) step(0, 1);
      repeat (6) step(0, 0);
      check("held_enable", {1'b0, o_enable}, {1'b0, !en_before});

      // Both buttons on the same edge
      mode_before = {o_switch_1, o_switch_2};
      en_before = o_enable;
      for (int k = 1; k <= 10; k++) begin
         step(1, 1);
         if (k == LAT) begin
            check("both_mode", {o_switch_1, o_switch_2}, mode_before + 2'd1);
            check("both_enable", {1'b0, o_enable}, {1'b0, !en_before});
         end
      end
      repeat (8) step(0, 0);

      // Reset mid-debounce with the mode button held
      repeat (SYNC + 2) step(1, 0);
      i_btn_mode = 1'b1;
      reset_pulse();
      for (int k = 1; k <= LAT + 3; k++) begin
         step(1, 0);
         if (k == LAT - 1) check("rst_pre", {o_switch_1, o_switch_2}, 2'b00);
         if (k == LAT) check("rst_press", {o_switch_1, o_switch_2}, 2'b01);
      end
      repeat (8) step(0, 0);

      // Random bouncing with occasional long holds
      rm = 0; re = 0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) rm = !rm;
         if ($urandom_range(0, 3) == 0) re = !re;
         if ($urandom_range(0, 15) == 0) begin
            repeat (LAT + 2) step(rm, re);
         end
         step(rm, re);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
